// File: rtl/axis_mil1553_decoder.sv
// axis_mil1553_decoder
//   MIL-STD-1553 receive decoder. Oversamples the Manchester II bus pair,
//   hunts for a complete 20-bit-time word (3-bit sync + 16 data + parity) on
//   every sample strobe and emits matched words on an AXI4-Stream master.
//
// Ports
//   aclk, arstn          system clock, synchronous active-low reset
//   diff[1:0]            bus pair (diff[1] positive line); equal lines = idle
//   m_axis_tdata[15:0]   decoded word, bit 15 = first bit on the bus
//   m_axis_tuser[7:0]    [7:6] 10 cmd/status sync, 01 data sync; [0] parity good
//   m_axis_tvalid/tready stream handshake; newest word overwrites an unaccepted one
//
// Build option
//   AXIS_1553_PARITY_FILTER_EN  when defined, words with bad parity are dropped.

module axis_mil1553_decoder #(
    parameter int clock_speed = 100_000_000,
    parameter int sample_rate = 2_000_000
) (
    input  logic        aclk,
    input  logic        arstn,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tuser,
    input  logic        m_axis_tready,
    input  logic [1:0]  diff
);

    localparam int SPB       = sample_rate / 1_000_000;
    localparam int CPS       = clock_speed / sample_rate;
    localparam int DEPTH     = 20 * SPB;
    localparam int HALF      = SPB / 2;
    localparam int SYNC_HALF = (3 * SPB) / 2;
    localparam int DIV_W     = $clog2(CPS);

    logic [1:0]       r_diff_m;
    logic [1:0]       r_diff_s;
    logic             r_lvl_q;
    logic [DIV_W-1:0] r_div;
    logic             r_strb_d;
    logic [DEPTH-1:0] r_lvl;
    logic [DEPTH-1:0] r_vld;

    logic                 w_edge;
    logic                 w_strobe;
    logic [SYNC_HALF-1:0] w_sync_a;
    logic [SYNC_HALF-1:0] w_sync_b;
    logic                 w_cmd_sync;
    logic                 w_dat_sync;
    logic [16:0]          w_cell_ok;
    logic [16:0]          w_bits;
    logic                 w_par_ok;
    logic                 w_match;
    logic                 w_emit;

    assign w_edge   = r_diff_s[1] ^ r_lvl_q;
    // A resync edge takes priority so a sample is never taken on a transition.
    assign w_strobe = (r_div == DIV_W'(CPS - 1)) && !w_edge;

    // Sync field: oldest 1.5 bit-times versus the following 1.5 bit-times.
    for (genvar g = 0; g < SYNC_HALF; g++) begin : g_sync
        assign w_sync_a[g] = r_lvl[DEPTH - 1 - g];
        assign w_sync_b[g] = r_lvl[DEPTH - 1 - SYNC_HALF - g];
    end
    assign w_cmd_sync = (&w_sync_a) & ~(|w_sync_b);
    assign w_dat_sync = ~(|w_sync_a) & (&w_sync_b);

    // 17 Manchester cells (16 data + parity); cell 0 is the first data bit.
    for (genvar g = 0; g < 17; g++) begin : g_cell
        localparam int B = DEPTH - 1 - 3 * SPB - g * SPB;
        logic [HALF-1:0] w_first;
        logic [HALF-1:0] w_second;
        assign w_first      = r_lvl[B -: HALF];
        assign w_second     = r_lvl[B - HALF -: HALF];
        assign w_cell_ok[g] = ((&w_first) | ~(|w_first)) &
                              ((&w_second) | ~(|w_second)) &
                              (w_first[HALF-1] != w_second[HALF-1]);
        assign w_bits[16 - g] = w_first[HALF-1];
    end

    assign w_par_ok = ^w_bits;
    // Evaluated the cycle after a strobe, once the new sample is in the register.
    assign w_match  = r_strb_d & (&r_vld) & (w_cmd_sync | w_dat_sync) & (&w_cell_ok);

`ifdef AXIS_1553_PARITY_FILTER_EN
    assign w_emit = w_match & w_par_ok;
`else
    assign w_emit = w_match;
`endif

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            r_diff_m      <= 2'b00;
            r_diff_s      <= 2'b00;
            r_lvl_q       <= 1'b0;
            r_div         <= '0;
            r_strb_d      <= 1'b0;
            r_lvl         <= '0;
            r_vld         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 16'h0000;
            m_axis_tuser  <= 8'h00;
        end else begin
            r_diff_m <= diff;
            r_diff_s <= r_diff_m;
            r_lvl_q  <= r_diff_s[1];
            r_strb_d <= w_strobe;

            // Reload to mid-count on a level change so strobes land mid half-bit.
            if (w_edge)
                r_div <= DIV_W'(CPS / 2);
            else if (r_div == DIV_W'(CPS - 1))
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            if (w_strobe) begin
                r_lvl <= {r_lvl[DEPTH-2:0], r_diff_s[1]};
                r_vld <= {r_vld[DEPTH-2:0], r_diff_s[1] ^ r_diff_s[0]};
            end else if (w_match) begin
                // Invalidate the consumed window so the word cannot match again.
                r_vld <= '0;
            end

            if (w_emit) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= w_bits[16:1];
                m_axis_tuser  <= {w_cmd_sync, w_dat_sync, 5'b00000, w_par_ok};
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_mil1553_decoder.sv
// tb_axis_mil1553_decoder
//   Drives Manchester II words onto the bus pair with real-time delays and
//   compares every accepted stream beat against a scoreboard of expected words.

`timescale 1ns/1ps

module tb_axis_mil1553_decoder;

    logic        aclk;
    logic        arstn;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tuser;
    logic        m_axis_tready;
    logic [1:0]  diff;

    int n_checks;
    int n_fail;
    logic [23:0] sb_q[$];

    axis_mil1553_decoder #(
        .clock_speed(100_000_000),
        .sample_rate(2_000_000)
    ) u_dut (
        .aclk         (aclk),
        .arstn        (arstn),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .diff         (diff)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One half bit-time (500 ns) at the given bus level.
    task automatic drive_half(input logic lvl);
        diff = lvl ? 2'b10 : 2'b01;
        #500;
    endtask

    task automatic idle_us(input int n);
        diff = 2'b11;
        #(n * 1000);
    endtask

    // viol_bit >= 0 holds that data cell high for the whole bit time.
    task automatic send_word(input logic cmd, input logic [15:0] d, input logic p,
                             input int viol_bit);
        logic [16:0] bits;
        bits = {d, p};
        for (int i = 0; i < 3; i++) drive_half(cmd);
        for (int i = 0; i < 3; i++) drive_half(~cmd);
        for (int k = 0; k < 17; k++) begin
            if (k == viol_bit) begin
                drive_half(1'b1);
                drive_half(1'b1);
            end else begin
                drive_half(bits[16 - k]);
                drive_half(~bits[16 - k]);
            end
        end
    endtask

    function automatic logic odd_par(input logic [15:0] d);
        return ~(^d);
    endfunction

    task automatic push_exp(input logic cmd, input logic [15:0] d, input logic p);
        sb_q.push_back({cmd, ~cmd, 5'b00000, ^{d, p}, d});
    endtask

    task automatic set_ready(input logic r);
        @(posedge aclk);
        #1 m_axis_tready = r;
    endtask

    always @(negedge aclk) begin
        if (arstn && m_axis_tvalid && m_axis_tready) begin
            logic [23:0] exp_w;
            chk("sb_word_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_w = sb_q.pop_front();
                chk("tdata", 32'(m_axis_tdata), 32'(exp_w[15:0]));
                chk("tuser", 32'(m_axis_tuser), 32'(exp_w[23:16]));
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        arstn         = 1'b0;
        m_axis_tready = 1'b1;
        diff          = 2'b11;

        // Reset held 1 us on an idle bus.
        for (int i = 0; i < 10; i++) begin
            repeat (10) @(negedge aclk);
            chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        @(posedge aclk);
        #1 arstn = 1'b1;
        @(negedge aclk);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
        chk("rst_tvalid_rel", 32'(m_axis_tvalid), 32'd0);
        idle_us(50);
        chk("idle_no_word", 32'(m_axis_tvalid), 32'd0);

        // Command sync, 0xFFFF, parity bit 1.
        push_exp(1'b1, 16'hFFFF, 1'b1);
        send_word(1'b1, 16'hFFFF, 1'b1, -1);
        idle_us(3);

        // Data sync, 0x0001, parity bit 0.
        push_exp(1'b0, 16'h0001, 1'b0);
        send_word(1'b0, 16'h0001, 1'b0, -1);
        idle_us(3);

        // Data sync, 0x1234, wrong parity bit.
`ifndef AXIS_1553_PARITY_FILTER_EN
        push_exp(1'b0, 16'h1234, ~odd_par(16'h1234));
`endif
        send_word(1'b0, 16'h1234, ~odd_par(16'h1234), -1);
        idle_us(3);
        chk("sb_after_badpar", 32'(sb_q.size()), 32'd0);

        // Back-to-back words with no gap.
        for (int i = 0; i < 20; i++) begin
            push_exp(1'b0, 16'(i), odd_par(16'(i)));
            send_word(1'b0, 16'(i), odd_par(16'(i)), -1);
        end
        idle_us(3);
        chk("sb_after_b2b", 32'(sb_q.size()), 32'd0);

        // Stalled stream: the newer word overwrites the unaccepted one.
        set_ready(1'b0);
        send_word(1'b0, 16'hAAAA, odd_par(16'hAAAA), -1);
        push_exp(1'b0, 16'h5555, odd_par(16'h5555));
        send_word(1'b0, 16'h5555, odd_par(16'h5555), -1);
        idle_us(1);
        chk("stall_tvalid_held", 32'(m_axis_tvalid), 32'd1);
        chk("stall_tdata_held", 32'(m_axis_tdata), 32'h5555);
        set_ready(1'b1);
        idle_us(2);
        chk("stall_one_transfer", 32'(m_axis_tvalid), 32'd0);

        // Manchester violation in data bit 5, then a clean word.
        send_word(1'b0, 16'h0000, odd_par(16'h0000), 5);
        idle_us(3);
        chk("viol_no_word", 32'(sb_q.size()), 32'd0);
        push_exp(1'b1, 16'h0F0F, odd_par(16'h0F0F));
        send_word(1'b1, 16'h0F0F, odd_par(16'h0F0F), -1);
        idle_us(3);

        for (int i = 0; i < 5000 && sb_q.size() != 0; i++) @(negedge aclk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
